// File: rtl/parking_alloc_ctrl.sv
// Two-class car-park controller: tracks uni/pub parked counts, capacities
// and free spaces, and moves capacity between the classes on hour changes.
`timescale 1ns/1ps
module parking_alloc_ctrl #(
   parameter int CNT_W      = 10,
   parameter int TOTAL_CAP  = 700,
   parameter int UNI_INIT   = 500,
   parameter int STEP       = 50,
   parameter int STEP_START = 13,
   parameter int FINAL_HOUR = 16,
   parameter int FINAL_PUB  = 500
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       hour,
   input  logic             entry_req,
   input  logic             entry_uni,
   input  logic             exit_req,
   input  logic             exit_uni,
   output logic [CNT_W-1:0] uni_parked,
   output logic [CNT_W-1:0] pub_parked,
   output logic [CNT_W-1:0] uni_cap,
   output logic [CNT_W-1:0] pub_cap,
   output logic [CNT_W-1:0] uni_free,
   output logic [CNT_W-1:0] pub_free,
   output logic             uni_avail,
   output logic             pub_avail,
   output logic             entry_ack,
   output logic             entry_rej,
   output logic             exit_err,
   output logic             realloc_ok,
   output logic             realloc_fail
);

   localparam int CW1 = CNT_W + 1;
   localparam logic [CNT_W-1:0] UNI_INIT_C  = CNT_W'(UNI_INIT);
   localparam logic [CNT_W-1:0] PUB_INIT_C  = CNT_W'(TOTAL_CAP - UNI_INIT);
   localparam logic [CNT_W-1:0] FIN_UNI_C   = CNT_W'(TOTAL_CAP - FINAL_PUB);
   localparam logic [CNT_W-1:0] FIN_PUB_C   = CNT_W'(FINAL_PUB);
   localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(STEP);
   localparam logic [CW1-1:0]   STEP_W      = CW1'(STEP);
   localparam logic [4:0]       STEP_LO     = 5'(STEP_START);
   localparam logic [4:0]       FIN_HOUR_C  = 5'(FINAL_HOUR);

   typedef enum logic [1:0] {S_PRIME, S_IDLE, S_EVAL} state_t;

   state_t           state_q, state_d;
   logic [4:0]       hour_q, hour_d;
   logic [CNT_W-1:0] uni_parked_q, uni_parked_d, pub_parked_q, pub_parked_d;
   logic [CNT_W-1:0] uni_cap_q, uni_cap_d, pub_cap_q, pub_cap_d;
   logic [CNT_W-1:0] uni_free_q, uni_free_d, pub_free_q, pub_free_d;
   logic             uni_avail_q, uni_avail_d, pub_avail_q, pub_avail_d;
   logic             entry_ack_q, entry_ack_d, entry_rej_q, entry_rej_d;
   logic             exit_err_q, exit_err_d;
   logic             realloc_ok_q, realloc_ok_d, realloc_fail_q, realloc_fail_d;

   logic uni_out, pub_out, uni_acc, pub_acc, uni_in, pub_in;

   // FSM state and sampled hour register; reset lands in PRIME so the hour
   // present at release is adopted without evaluation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_PRIME;
         hour_q  <= '0;
      end else begin
         state_q <= state_d;
         hour_q  <= hour_d;
      end
   end

   // Next-state: adopt the hour after reset, detect hour changes in IDLE.
   always_comb begin
      state_d = state_q;
      hour_d  = hour_q;
      case (state_q)
         S_PRIME: begin
            hour_d  = hour;
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (hour != hour_q) begin
               hour_d  = hour;
               state_d = S_EVAL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Gate events: an exit of the same class frees the space a blocked entry needs.
   always_comb begin
      uni_out     = exit_req & exit_uni & (uni_parked_q != '0);
      pub_out     = exit_req & ~exit_uni & (pub_parked_q != '0);
      uni_acc     = (uni_free_q != '0) | uni_out;
      pub_acc     = (pub_free_q != '0) | pub_out;
      uni_in      = entry_req & entry_uni & uni_acc;
      pub_in      = entry_req & ~entry_uni & pub_acc;
      entry_ack_d = uni_in | pub_in;
      entry_rej_d = entry_req & ~(entry_uni ? uni_acc : pub_acc);
      exit_err_d  = exit_req & (exit_uni ? (uni_parked_q == '0) : (pub_parked_q == '0));
      uni_parked_d = uni_parked_q + CNT_W'(uni_in) - CNT_W'(uni_out);
      pub_parked_d = pub_parked_q + CNT_W'(pub_in) - CNT_W'(pub_out);
   end

   // FSM outputs: capacity rule for the sampled hour, checked against post-event counts.
   always_comb begin
      uni_cap_d      = uni_cap_q;
      pub_cap_d      = pub_cap_q;
      realloc_ok_d   = 1'b0;
      realloc_fail_d = 1'b0;
      if (state_q == S_EVAL) begin
         if (hour_q >= STEP_LO && hour_q < FIN_HOUR_C) begin
            if (({1'b0, uni_parked_d} + STEP_W) <= {1'b0, uni_cap_q}) begin
               uni_cap_d    = uni_cap_q - STEP_C;
               pub_cap_d    = pub_cap_q + STEP_C;
               realloc_ok_d = 1'b1;
            end else begin
               realloc_fail_d = 1'b1;
            end
         end else if (hour_q == FIN_HOUR_C) begin
            if (uni_parked_d <= FIN_UNI_C) begin
               uni_cap_d    = FIN_UNI_C;
               pub_cap_d    = FIN_PUB_C;
               realloc_ok_d = 1'b1;
            end else begin
               realloc_fail_d = 1'b1;
            end
         end else if (hour_q == 5'd0) begin
            if (pub_parked_d <= PUB_INIT_C) begin
               uni_cap_d    = UNI_INIT_C;
               pub_cap_d    = PUB_INIT_C;
               realloc_ok_d = 1'b1;
            end else begin
               realloc_fail_d = 1'b1;
            end
         end
      end
      uni_free_d  = uni_cap_d - uni_parked_d;
      pub_free_d  = pub_cap_d - pub_parked_d;
      uni_avail_d = (uni_free_d != '0);
      pub_avail_d = (pub_free_d != '0);
   end

   // Registered counts, capacities, free spaces and one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uni_parked_q   <= '0;
         pub_parked_q   <= '0;
         uni_cap_q      <= UNI_INIT_C;
         pub_cap_q      <= PUB_INIT_C;
         uni_free_q     <= UNI_INIT_C;
         pub_free_q     <= PUB_INIT_C;
         uni_avail_q    <= (UNI_INIT_C != '0);
         pub_avail_q    <= (PUB_INIT_C != '0);
         entry_ack_q    <= 1'b0;
         entry_rej_q    <= 1'b0;
         exit_err_q     <= 1'b0;
         realloc_ok_q   <= 1'b0;
         realloc_fail_q <= 1'b0;
      end else begin
         uni_parked_q   <= uni_parked_d;
         pub_parked_q   <= pub_parked_d;
         uni_cap_q      <= uni_cap_d;
         pub_cap_q      <= pub_cap_d;
         uni_free_q     <= uni_free_d;
         pub_free_q     <= pub_free_d;
         uni_avail_q    <= uni_avail_d;
         pub_avail_q    <= pub_avail_d;
         entry_ack_q    <= entry_ack_d;
         entry_rej_q    <= entry_rej_d;
         exit_err_q     <= exit_err_d;
         realloc_ok_q   <= realloc_ok_d;
         realloc_fail_q <= realloc_fail_d;
      end
   end

   assign uni_parked   = uni_parked_q;
   assign pub_parked   = pub_parked_q;
   assign uni_cap      = uni_cap_q;
   assign pub_cap      = pub_cap_q;
   assign uni_free     = uni_free_q;
   assign pub_free     = pub_free_q;
   assign uni_avail    = uni_avail_q;
   assign pub_avail    = pub_avail_q;
   assign entry_ack    = entry_ack_q;
   assign entry_rej    = entry_rej_q;
   assign exit_err     = exit_err_q;
   assign realloc_ok   = realloc_ok_q;
   assign realloc_fail = realloc_fail_q;

endmodule

// File: tb/tb_parking_alloc_ctrl.sv
// Testbench for parking_alloc_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural car-park model.
`timescale 1ns/1ps
module tb_parking_alloc_ctrl;

   localparam int CNT_W      = 10;
   localparam int TOTAL_CAP  = 700;
   localparam int UNI_INIT   = 500;
   localparam int STEP       = 50;
   localparam int STEP_START = 13;
   localparam int FINAL_HOUR = 16;
   localparam int FINAL_PUB  = 500;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       hour;
   logic             entry_req, entry_uni, exit_req, exit_uni;
   logic [CNT_W-1:0] uni_parked, pub_parked, uni_cap, pub_cap, uni_free, pub_free;
   logic             uni_avail, pub_avail, entry_ack, entry_rej, exit_err;
   logic             realloc_ok, realloc_fail;

   parking_alloc_ctrl #(
      .CNT_W(CNT_W), .TOTAL_CAP(TOTAL_CAP), .UNI_INIT(UNI_INIT), .STEP(STEP),
      .STEP_START(STEP_START), .FINAL_HOUR(FINAL_HOUR), .FINAL_PUB(FINAL_PUB)
   ) dut (
      .clk(clk), .rst(rst), .hour(hour),
      .entry_req(entry_req), .entry_uni(entry_uni),
      .exit_req(exit_req), .exit_uni(exit_uni),
      .uni_parked(uni_parked), .pub_parked(pub_parked),
      .uni_cap(uni_cap), .pub_cap(pub_cap),
      .uni_free(uni_free), .pub_free(pub_free),
      .uni_avail(uni_avail), .pub_avail(pub_avail),
      .entry_ack(entry_ack), .entry_rej(entry_rej), .exit_err(exit_err),
      .realloc_ok(realloc_ok), .realloc_fail(realloc_fail)
   );

   always #5 clk = ~clk;

   // Reference model state: counts, capacities, last adopted hour, pending evaluation.
   int m_up, m_pp, m_uc, m_pc, m_seen;
   bit m_primed, m_eval;
   bit m_ack, m_rej, m_err, m_ok, m_fail;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int ack_cnt, ok_cnt, fail_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
      n_chk++;
      assert (obs === req) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, req);
      end
   endtask

   task automatic model_reset();
      m_up = 0; m_pp = 0;
      m_uc = UNI_INIT; m_pc = TOTAL_CAP - UNI_INIT;
      m_primed = 0; m_eval = 0; m_seen = 0;
      m_ack = 0; m_rej = 0; m_err = 0; m_ok = 0; m_fail = 0;
   endtask

   task automatic model_update(input bit er, input bit eu, input bit xr, input bit xu);
      bit u_out, p_out, u_acc, p_acc, u_in, p_in;
      u_out = xr && xu && (m_up > 0);
      p_out = xr && !xu && (m_pp > 0);
      u_acc = (m_uc - m_up > 0) || u_out;
      p_acc = (m_pc - m_pp > 0) || p_out;
      u_in  = er && eu && u_acc;
      p_in  = er && !eu && p_acc;
      m_ack = u_in || p_in;
      m_rej = er && !m_ack;
      m_err = xr && (xu ? (m_up == 0) : (m_pp == 0));
      m_up  = m_up + int'(u_in) - int'(u_out);
      m_pp  = m_pp + int'(p_in) - int'(p_out);
      m_ok = 0; m_fail = 0;
      if (m_eval) begin
         if (m_seen >= STEP_START && m_seen < FINAL_HOUR) begin
            if (m_up <= m_uc - STEP) begin m_uc -= STEP; m_pc += STEP; m_ok = 1; end
            else m_fail = 1;
         end else if (m_seen == FINAL_HOUR) begin
            if (m_up <= TOTAL_CAP - FINAL_PUB) begin
               m_uc = TOTAL_CAP - FINAL_PUB; m_pc = FINAL_PUB; m_ok = 1;
            end else m_fail = 1;
         end else if (m_seen == 0) begin
            if (m_pp <= TOTAL_CAP - UNI_INIT) begin
               m_uc = UNI_INIT; m_pc = TOTAL_CAP - UNI_INIT; m_ok = 1;
            end else m_fail = 1;
         end
      end
      if (!m_primed) begin
         m_primed = 1; m_seen = int'(hour); m_eval = 0;
      end else if (m_eval) begin
         m_eval = 0;
      end else if (int'(hour) != m_seen) begin
         m_seen = int'(hour); m_eval = 1;
      end
   endtask

   task automatic check_all();
      chk("uni_parked", 16'(uni_parked), 16'(m_up));
      chk("pub_parked", 16'(pub_parked), 16'(m_pp));
      chk("uni_cap", 16'(uni_cap), 16'(m_uc));
      chk("pub_cap", 16'(pub_cap), 16'(m_pc));
      chk("uni_free", 16'(uni_free), 16'(m_uc - m_up));
      chk("pub_free", 16'(pub_free), 16'(m_pc - m_pp));
      chk("uni_avail", 16'(uni_avail), 16'(m_uc > m_up));
      chk("pub_avail", 16'(pub_avail), 16'(m_pc > m_pp));
      chk("entry_ack", 16'(entry_ack), 16'(m_ack));
      chk("entry_rej", 16'(entry_rej), 16'(m_rej));
      chk("exit_err", 16'(exit_err), 16'(m_err));
      chk("realloc_ok", 16'(realloc_ok), 16'(m_ok));
      chk("realloc_fail", 16'(realloc_fail), 16'(m_fail));
   endtask

   task automatic step(input bit er, input bit eu, input bit xr, input bit xu);
      entry_req = er; entry_uni = eu; exit_req = xr; exit_uni = xu;
      model_update(er, eu, xr, xu);
      @(posedge clk);
      #1;
      entry_req = 0; entry_uni = 0; exit_req = 0; exit_uni = 0;
      check_all();
      if (entry_ack)    ack_cnt++;
      if (realloc_ok)   ok_cnt++;
      if (realloc_fail) fail_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; hour = 5'd12;
      entry_req = 0; entry_uni = 0; exit_req = 0; exit_uni = 0;
      ack_cnt = 0; ok_cnt = 0; fail_cnt = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_uni_free", 16'(uni_free), 16'd500);
      chk("rst_pub_cap", 16'(pub_cap), 16'd200);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Basic entries
      ack_cnt = 0;
      repeat (3) step(1, 1, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      chk("t1_uni_parked", 16'(uni_parked), 16'd3);
      chk("t1_uni_free", 16'(uni_free), 16'd497);
      chk("t1_pub_parked", 16'(pub_parked), 16'd2);
      chk("t1_pub_free", 16'(pub_free), 16'd198);
      chk("t1_ack_count", 16'(ack_cnt), 16'd5);

      // Pub full, refusal, and entry paired with an exit
      repeat (198) step(1, 0, 0, 0);
      chk("t2_pub_full", 16'(pub_parked), 16'd200);
      step(1, 0, 0, 0);
      chk("t2_rej", 16'(entry_rej), 16'd1);
      chk("t2_rej_count", 16'(pub_parked), 16'd200);
      step(1, 0, 1, 0);
      chk("t2_pair_ack", 16'(entry_ack), 16'd1);
      chk("t2_pair_count", 16'(pub_parked), 16'd200);

      // Afternoon handover and final split
      repeat (7) step(1, 1, 0, 0);
      chk("t3_uni_parked", 16'(uni_parked), 16'd10);
      ok_cnt = 0;
      for (int h = 13; h <= 15; h++) begin
         hour = 5'(h);
         idle(3);
      end
      chk("t3_ok_count", 16'(ok_cnt), 16'd3);
      chk("t3_uni_cap", 16'(uni_cap), 16'd350);
      chk("t3_pub_cap", 16'(pub_cap), 16'd350);
      hour = 5'd16;
      idle(3);
      chk("t3_final_uni", 16'(uni_cap), 16'd200);
      chk("t3_final_pub", 16'(pub_cap), 16'd500);

      // Refused step, exit underflow
      hour = 5'd12;
      do_reset();
      idle(1);
      repeat (460) step(1, 1, 0, 0);
      fail_cnt = 0; ok_cnt = 0;
      hour = 5'd13;
      idle(4);
      chk("t4_fail_count", 16'(fail_cnt), 16'd1);
      chk("t4_ok_count", 16'(ok_cnt), 16'd0);
      chk("t4_uni_cap", 16'(uni_cap), 16'd500);
      hour = 5'd12;
      do_reset();
      idle(1);
      step(0, 0, 1, 1);
      chk("t4_exit_err", 16'(exit_err), 16'd1);
      chk("t4_exit_parked", 16'(uni_parked), 16'd0);

      // Reset while evaluating, hour held afterwards
      hour = 5'd13;
      step(0, 0, 0, 0);
      do_reset();
      ok_cnt = 0; fail_cnt = 0;
      idle(5);
      chk("t5_no_realloc", 16'(ok_cnt + fail_cnt), 16'd0);
      chk("t5_uni_cap", 16'(uni_cap), 16'd500);

      // Midnight restore refused, then accepted
      hour = 5'd12;
      do_reset();
      idle(1);
      for (int h = 13; h <= 16; h++) begin
         hour = 5'(h);
         idle(3);
      end
      chk("t6_pub_cap", 16'(pub_cap), 16'd500);
      repeat (300) step(1, 0, 0, 0);
      fail_cnt = 0;
      hour = 5'd0;
      idle(3);
      chk("t6_fail_count", 16'(fail_cnt), 16'd1);
      chk("t6_pub_kept", 16'(pub_cap), 16'd500);
      repeat (150) step(0, 0, 1, 0);
      hour = 5'd1;
      idle(3);
      ok_cnt = 0;
      hour = 5'd0;
      idle(3);
      chk("t6_ok_count", 16'(ok_cnt), 16'd1);
      chk("t6_uni_restored", 16'(uni_cap), 16'd500);
      chk("t6_pub_restored", 16'(pub_cap), 16'd200);

      // Random traffic and hour changes
      hour = 5'd12;
      do_reset();
      idle(1);
      for (int i = 0; i < 4000; i++) begin
         bit er, eu, xr, xu;
         er = ($urandom_range(0, 99) < 60);
         eu = $urandom_range(0, 1) == 1;
         xr = ($urandom_range(0, 99) < 40);
         xu = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 99) < 3) hour = 5'($urandom_range(0, 23));
         step(er, eu, xr, xu);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
